// File: rtl/mult_arbiter_if.sv
// Requester-side bus of the multiplier arbiter: request/operand inputs and
// the ack/done/result/err/busy responses, one bit or slice per requester.
interface mult_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req;
  logic [16*NREQ-1:0] a_in;
  logic [16*NREQ-1:0] b_in;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    done;
  logic [31:0]        result;
  logic               err;
  logic               busy;

  // Requesters drive requests and operands and observe the responses.
  modport master (
    output req, a_in, b_in,
    input  ack, done, result, err, busy
  );

  // The arbiter samples requests and operands and drives the responses.
  modport slave (
    input  req, a_in, b_in,
    output ack, done, result, err, busy
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one 16x16 shift-add multiplier among NREQ
// requesters. A winner's operands are latched and presented on mul_a/mul_b
// with mul_trig high until mul_fin (or a watchdog abort); the product is
// returned with a one-cycle done pulse, then mul_trig is held low for
// IDLE_GAP cycles so the multiplier clears before the next operation.
// Optional build macro MULT_ARB_STATS_EN adds op_count/to_count outputs.
module mult_arbiter #(
  parameter int NREQ     = 4,
  parameter int TIMEOUT  = 40,
  parameter int IDLE_GAP = 2
) (
  input  logic          clk,
  input  logic          rst,
  mult_arbiter_if.slave bus,
  output logic          mul_trig,
  output logic [15:0]   mul_a,
  output logic [15:0]   mul_b,
  input  logic [31:0]   mul_c,
  input  logic          mul_fin
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [15:0]   op_count,
  output logic [7:0]    to_count
`endif
);

  localparam int DATA_W = 16;
  localparam int PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW     = $clog2(TIMEOUT + 1);
  localparam int GW     = $clog2(IDLE_GAP + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [31:0]         result_q, result_d;
  logic                trig_q, trig_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [PW-1:0]       idx_q, idx_d;
  logic [PW-1:0]       rr_q, rr_d;
  logic [WW-1:0]       wcnt_q, wcnt_d;
  logic [GW-1:0]       gcnt_q, gcnt_d;

  logic                win_vld;
  logic [PW-1:0]       win_idx;
  logic [DATA_W-1:0]   a_sel;
  logic [DATA_W-1:0]   b_sel;

  // Round-robin pick: first requester at or above rr_q, wrapping modulo NREQ.
  // Scanning offsets from high to low lets the smallest offset win.
  always_comb begin
    int j;
    win_vld = 1'b0;
    win_idx = '0;
    j       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (bus.req[j]) begin
        win_vld = 1'b1;
        win_idx = PW'(j);
      end
    end
  end

  // Operand mux selecting the winner's A/B slices.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == win_idx) begin
        a_sel = bus.a_in[DATA_W*i +: DATA_W];
        b_sel = bus.b_in[DATA_W*i +: DATA_W];
      end
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d  = state_q;
    ack_d    = '0;
    done_d   = '0;
    err_d    = 1'b0;
    result_d = result_q;
    trig_d   = trig_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    rr_d     = rr_q;
    wcnt_d   = wcnt_q;
    gcnt_d   = gcnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          a_d            = a_sel;
          b_d            = b_sel;
          ack_d[win_idx] = 1'b1;
          trig_d         = 1'b1;
          idx_d          = win_idx;
          rr_d           = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          wcnt_d         = '0;
          state_d        = S_RUN;
        end
      end

      S_RUN: begin
        wcnt_d = wcnt_q + 1'b1;
        // fin takes priority over a coinciding watchdog expiry
        if (mul_fin) begin
          result_d      = mul_c;
          done_d[idx_q] = 1'b1;
          trig_d        = 1'b0;
          gcnt_d        = '0;
          state_d       = S_GAP;
        end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
          result_d      = '0;
          done_d[idx_q] = 1'b1;
          err_d         = 1'b1;
          trig_d        = 1'b0;
          gcnt_d        = '0;
          state_d       = S_GAP;
        end
      end

      S_GAP: begin
        // requests are ignored here; mul_trig stays low for IDLE_GAP cycles
        if (gcnt_q == GW'(IDLE_GAP - 1)) begin
          gcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end

      default: begin
        trig_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops any in-flight operation silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ack_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      trig_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      rr_q     <= '0;
      wcnt_q   <= '0;
      gcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      trig_q   <= trig_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      rr_q     <= rr_d;
      wcnt_q   <= wcnt_d;
      gcnt_q   <= gcnt_d;
    end
  end

  assign bus.ack    = ack_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;
  assign bus.result = result_q;
  assign mul_trig   = trig_q;
  assign mul_a      = a_q;
  assign mul_b      = b_q;

`ifdef MULT_ARB_STATS_EN
  logic [15:0] op_q;
  logic [7:0]  to_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Saturating counters of completed operations and of watchdog aborts.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0;
      to_q <= '0;
    end else begin
      if (|done_d) op_q <= sat_inc16(op_q);
      if (err_d)   to_q <= sat_inc8(to_q);
    end
  end

  assign op_count = op_q;
  assign to_count = to_q;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: a behavioural multiplier model plus a
// transaction-level reference (round-robin pick, product or abort, latency).
module tb_mult_arbiter;
  localparam int NREQ     = 4;
  localparam int TIMEOUT  = 40;
  localparam int IDLE_GAP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mul_trig;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_c = '0;
  logic        mul_fin = 1'b0;
`ifdef MULT_ARB_STATS_EN
  logic [15:0] op_count;
  logic [7:0]  to_count;
`endif

  mult_arbiter_if #(.NREQ(NREQ)) bus ();

  mult_arbiter #(
    .NREQ(NREQ), .TIMEOUT(TIMEOUT), .IDLE_GAP(IDLE_GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .mul_trig(mul_trig),
    .mul_a(mul_a),
    .mul_b(mul_b),
    .mul_c(mul_c),
    .mul_fin(mul_fin)
`ifdef MULT_ARB_STATS_EN
    ,
    .op_count(op_count),
    .to_count(to_count)
`endif
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int rr_m = 0;
  int fin_lat = 0;
  int tcnt = 0;
  int prev_done_c = -1;
  int op_m = 0;
  int to_m = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 time unit after the edge, then advance the
  // multiplier model (fin raised lat cycles after trig, held while trig).
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mul_trig) begin
      if (fin_lat != 0 && tcnt >= fin_lat) begin
        mul_fin = 1'b1;
        mul_c   = 32'(mul_a) * 32'(mul_b);
      end else begin
        mul_fin = 1'b0;
        mul_c   = $urandom;
      end
      tcnt++;
    end else begin
      tcnt    = 0;
      mul_fin = 1'b0;
      mul_c   = $urandom;
    end
  endtask

  task automatic do_op(input logic [NREQ-1:0] mask, input logic [16*NREQ-1:0] av,
                       input logic [16*NREQ-1:0] bv, input int lat, input bit drop);
    int w, t, ack_c, done_c, exp_lat;
    bit trig_early, exp_err, hold_bad;
    logic [15:0] ea, eb;
    logic [31:0] exp_r;
    fin_lat = lat;
    bus.req  = mask;
    bus.a_in = av;
    bus.b_in = bv;
    w = -1;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && mask[(rr_m + k) % NREQ]) w = (rr_m + k) % NREQ;
    rr_m    = (w + 1) % NREQ;
    ea      = av[16*w +: 16];
    eb      = bv[16*w +: 16];
    exp_err = (lat == 0) || (lat >= TIMEOUT);
    exp_r   = exp_err ? 32'd0 : 32'(ea) * 32'(eb);
    exp_lat = exp_err ? TIMEOUT : lat + 1;
    op_m++;
    if (exp_err) to_m++;

    trig_early = 1'b0;
    t = 0;
    while (bus.ack == '0 && t < 200) begin
      if (mul_trig) trig_early = 1'b1;
      tick();
      t++;
    end
    chk("ack_seen", 32'(bus.ack != '0), 32'd1);
    if (bus.ack == '0) return;
    ack_c = cyc;
    chk("trig_low_before_issue", 32'(trig_early), 32'd0);
    chk("ack_winner", 32'(bus.ack), 32'd1 << w);
    chk("mul_a", 32'(mul_a), 32'(ea));
    chk("mul_b", 32'(mul_b), 32'(eb));
    chk("trig_on", 32'(mul_trig), 32'd1);
    chk("busy_run", 32'(bus.busy), 32'd1);
    if (prev_done_c >= 0) chk("issue_spacing", 32'(ack_c - prev_done_c), 32'(IDLE_GAP + 1));

    if (drop) bus.req = '0;
    tick();
    chk("ack_pulse", 32'(bus.ack), 32'd0);
    hold_bad = 1'b0;
    t = 0;
    while (bus.done == '0 && t < TIMEOUT + 10) begin
      if (mul_a !== ea || mul_b !== eb || bus.ack != '0 || mul_trig !== 1'b1) hold_bad = 1'b1;
      tick();
      t++;
    end
    chk("done_seen", 32'(bus.done != '0), 32'd1);
    if (bus.done == '0) return;
    done_c = cyc;
    chk("done_winner", 32'(bus.done), 32'd1 << w);
    chk("result", bus.result, exp_r);
    chk("err", 32'(bus.err), 32'(exp_err));
    chk("done_latency", 32'(done_c - ack_c), 32'(exp_lat));
    chk("run_hold", 32'(hold_bad), 32'd0);
    chk("trig_off", 32'(mul_trig), 32'd0);
    prev_done_c = done_c;

    tick();
    chk("done_pulse", 32'(bus.done), 32'd0);
    chk("err_pulse", 32'(bus.err), 32'd0);
    chk("result_hold", bus.result, exp_r);
    chk("busy_gap", 32'(bus.busy), 32'(IDLE_GAP > 1));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rr_m = 0;
    op_m = 0;
    to_m = 0;
    prev_done_c = -1;
  endtask

  initial begin
    logic [NREQ-1:0]    mask;
    logic [16*NREQ-1:0] av, bv;
    int sel, lat, t;
    bit seen_done;

    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_trig", 32'(mul_trig), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    tick();

    // single operation, fin 17 cycles after trig
    do_op(4'b0001, {16'd0, 16'd0, 16'd0, 16'd300}, {16'd0, 16'd0, 16'd0, 16'd200}, 17, 1'b1);

    // round robin with all requesters held, then pointer wrap on 1001
    pulse_reset();
    for (int n = 0; n < 8; n++)
      do_op(4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, {4{16'd10}}, 5 + n, 1'b0);
    do_op(4'b1001, {16'd7, 16'd3, 16'd2, 16'd5}, {4{16'd11}}, 6, 1'b0);
    do_op(4'b1001, {16'd7, 16'd3, 16'd2, 16'd5}, {4{16'd11}}, 6, 1'b1);

    // watchdog abort, fin/timeout coincidence, fin one cycle too late
    do_op(4'b0010, {4{16'd9}}, {4{16'd9}}, 0, 1'b1);
    do_op(4'b0100, {4{16'd12}}, {4{16'd13}}, TIMEOUT - 1, 1'b1);
    do_op(4'b1000, {4{16'd12}}, {4{16'd13}}, TIMEOUT, 1'b1);

    // edge operands
    do_op(4'b0001, {4{16'hFFFF}}, {4{16'hFFFF}}, 3, 1'b1);
    do_op(4'b0010, {4{16'h0000}}, {4{16'h1234}}, 1, 1'b1);
    do_op(4'b0100, {4{16'h8000}}, {4{16'h0002}}, 2, 1'b1);

    // reset in the middle of a run
    fin_lat  = 0;
    bus.req  = 4'b0100;
    bus.a_in = {4{16'h00AA}};
    bus.b_in = {4{16'h0055}};
    t = 0;
    while (bus.ack == '0 && t < 50) begin
      tick();
      t++;
    end
    chk("rstmid_ack", 32'(bus.ack), 32'b0100);
    bus.req = '0;
    repeat (5) tick();
    pulse_reset();
    chk("rstmid_trig", 32'(mul_trig), 32'd0);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_done", 32'(bus.done), 32'd0);
    chk("rstmid_result", bus.result, 32'd0);
    chk("rstmid_mul_a", 32'(mul_a), 32'd0);
    seen_done = 1'b0;
    for (int n = 0; n < TIMEOUT + 5; n++) begin
      tick();
      if (bus.done != '0) seen_done = 1'b1;
    end
    chk("rstmid_no_done", 32'(seen_done), 32'd0);
    do_op(4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, {4{16'd3}}, 4, 1'b1);
    do_op(4'b0100, {16'd4, 16'd3, 16'd2, 16'd1}, {4{16'd3}}, 4, 1'b1);
    do_op(4'b0001, {4{16'd77}}, {4{16'd2}}, 0, 1'b1);

    // randomized traffic against the reference
    for (int n = 0; n < 20; n++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      av   = {$urandom, $urandom};
      bv   = {$urandom, $urandom};
      sel  = $urandom_range(0, 7);
      lat  = (sel == 0) ? 0 : (sel == 1) ? TIMEOUT - 1 : $urandom_range(1, TIMEOUT - 2);
      do_op(mask, av, bv, lat, 1'($urandom_range(0, 1)));
    end

`ifdef MULT_ARB_STATS_EN
    chk("op_count", 32'(op_count), 32'(op_m));
    chk("to_count", 32'(to_count), 32'(to_m));
`endif

    bus.req = '0;
    repeat (4) tick();
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
